// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII receive framer.
//   - nibble constants for the preamble and start-of-frame delimiter
//   - receive FSM state encoding
//   - FIFO entry layout {err, last, data[7:0]} and a helper to build one
package rgmii_pkg;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;

  localparam int ENTRY_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic       err;
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  function automatic fifo_entry_t make_entry(input logic [7:0] data,
                                             input logic       last,
                                             input logic       err);
    fifo_entry_t e;
    e.data = data;
    e.last = last;
    e.err  = err;
    return e;
  endfunction

endpackage

// File: rtl/rgmii_byte_fifo.sv
// First-word-fall-through FIFO for framed receive bytes.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   push, push_data      write request (ignored when full) and entry
//   pop                  read request (ignored when empty)
//   pop_data             head entry, forced to zero while empty
//   empty                no entries stored
//   count, free          occupied / free entries (log2(DEPTH)+1 bits)
// Pointers carry one extra wrap bit, so count is a plain subtraction and
// a simultaneous push and pop leaves the count unchanged.
module rgmii_byte_fifo
  import rgmii_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign free    = DEPTH_C - count;
  assign empty   = (count == '0);
  assign do_push = push && (count != DEPTH_C);
  assign do_pop  = pop && !empty;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because the read port is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: strips preamble/SFD from clk-domain RGMII nibbles,
// packs nibble pairs (low nibble first) into bytes and streams them out of
// a FWFT FIFO with end-of-frame and error tags.
// Ports:
//   clk                      system clock
//   SW0                      asynchronous active-low reset
//   nib_valid, rx_en, rx_d   nibble strobe, RX_DV and data nibble
//   out_data/out_valid/out_ready/out_last/out_err   byte stream
//   frame_cnt, err_cnt       good / bad frame counters
// Build option: define RGMII_RX_STATS_EN to build the saturating frame and
// error counters; otherwise both outputs are tied to zero.
//
// The newest byte is parked in a hold register so that when the frame ends
// it can be pushed with last=1. Ordinary data pushes keep two FIFO slots
// free, so a terminator always has room after an overflow.
module rgmii_rx_framer
  import rgmii_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int MAX_FRAME    = 1522,
  parameter int MIN_PREAMBLE = 6
) (
  input  logic        clk,
  input  logic        SW0,
  input  logic        nib_valid,
  input  logic        rx_en,
  input  logic [3:0]  rx_d,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        out_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  FIFO_DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]  DATA_MIN_FREE = (AW+1)'(3);
  localparam logic [7:0]   MIN_PRE_C     = 8'(MIN_PREAMBLE);
  localparam logic [15:0]  MAX_FRAME_C   = 16'(MAX_FRAME);

  rx_state_e   state_q, state_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  lo_q, lo_d;
  logic        odd_q, odd_d;
  logic        hold_valid_q, hold_valid_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        term_pend_q, term_pend_d;

  logic        push;
  fifo_entry_t push_entry;
  logic        empty_frame;
  logic [7:0]  new_byte;
  logic [15:0] new_cnt;

  logic [ENTRY_W-1:0] pop_data;
  fifo_entry_t        pop_entry;
  logic               fifo_empty;
  logic               fifo_full;
  logic [AW:0]        fifo_count;
  logic [AW:0]        fifo_free;

  assign new_byte  = {rx_d, lo_q};
  assign new_cnt   = byte_cnt_q + 16'd1;
  assign fifo_full = (fifo_count == FIFO_DEPTH_C);

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    lo_d         = lo_q;
    odd_d        = odd_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    byte_cnt_d   = byte_cnt_q;
    term_pend_d  = term_pend_q;
    push         = 1'b0;
    push_entry   = '0;
    empty_frame  = 1'b0;

    // A pending terminator only exists in DROP/IDLE, where no other push
    // can occur, so it never competes with a data push.
    if (term_pend_q && !fifo_full) begin
      push        = 1'b1;
      push_entry  = make_entry(8'h00, 1'b1, 1'b1);
      term_pend_d = 1'b0;
    end

    if (nib_valid) begin
      unique case (state_q)
        IDLE: begin
          if (rx_en && rx_d == PREAMBLE_NIB && !term_pend_q) begin
            state_d   = PRE;
            pre_cnt_d = 8'd1;
          end
        end

        PRE: begin
          if (!rx_en) begin
            state_d = IDLE;
          end else if (rx_d == PREAMBLE_NIB) begin
            if (pre_cnt_q != 8'hFF) pre_cnt_d = pre_cnt_q + 8'd1;
          end else if (rx_d == SFD_NIB && pre_cnt_q >= MIN_PRE_C) begin
            state_d      = DATA;
            odd_d        = 1'b0;
            hold_valid_d = 1'b0;
            byte_cnt_d   = 16'd0;
          end else begin
            state_d = IDLE;
          end
        end

        DATA: begin
          if (!rx_en) begin
            state_d      = IDLE;
            hold_valid_d = 1'b0;
            odd_d        = 1'b0;
            if (!hold_valid_q) begin
              empty_frame = 1'b1;
            end else if (fifo_full) begin
              // No room for the final byte; it is lost and the frame is
              // closed by a deferred error terminator instead.
              term_pend_d = 1'b1;
            end else begin
              push       = 1'b1;
              push_entry = make_entry(hold_data_q, 1'b1, odd_q);
            end
          end else if (!odd_q) begin
            lo_d  = rx_d;
            odd_d = 1'b1;
          end else begin
            odd_d      = 1'b0;
            byte_cnt_d = new_cnt;
            if (new_cnt > MAX_FRAME_C) begin
              // Byte MAX_FRAME+1: close the frame on the held byte.
              state_d      = DROP;
              hold_valid_d = 1'b0;
              if (fifo_full || !hold_valid_q) begin
                term_pend_d = 1'b1;
              end else begin
                push       = 1'b1;
                push_entry = make_entry(hold_data_q, 1'b1, 1'b1);
              end
            end else if (hold_valid_q) begin
              if (fifo_free < DATA_MIN_FREE) begin
                state_d      = DROP;
                hold_valid_d = 1'b0;
                term_pend_d  = 1'b1;
              end else begin
                push        = 1'b1;
                push_entry  = make_entry(hold_data_q, 1'b0, 1'b0);
                hold_data_d = new_byte;
              end
            end else begin
              hold_valid_d = 1'b1;
              hold_data_d  = new_byte;
            end
          end
        end

        DROP: begin
          if (!rx_en) state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge SW0) begin
    if (!SW0) begin
      state_q      <= IDLE;
      pre_cnt_q    <= '0;
      lo_q         <= '0;
      odd_q        <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      byte_cnt_q   <= '0;
      term_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      lo_q         <= lo_d;
      odd_q        <= odd_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      byte_cnt_q   <= byte_cnt_d;
      term_pend_q  <= term_pend_d;
    end
  end

  rgmii_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (SW0),
    .push      (push),
    .push_data (push_entry),
    .pop       (out_valid && out_ready),
    .pop_data  (pop_data),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .free      (fifo_free)
  );

  assign pop_entry = pop_data;
  assign out_valid = !fifo_empty;
  assign out_data  = pop_entry.data;
  assign out_last  = pop_entry.last;
  assign out_err   = pop_entry.err;

`ifdef RGMII_RX_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (push && push_entry.last && !push_entry.err && frame_cnt_q != 16'hFFFF)
      frame_cnt_d = frame_cnt_q + 16'd1;
    if (((push && push_entry.err) || empty_frame) && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge SW0) begin
    if (!SW0) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  logic stats_unused;
  assign stats_unused = empty_frame;
  assign frame_cnt    = 16'd0;
  assign err_cnt      = 16'd0;
`endif

endmodule
